// File: rtl/pe_divider.sv
// pe_divider: sequential radix-2 restoring divider for the BDPU processing element.
// Produces one quotient bit per clock behind a start/busy/done handshake.
// Optional feature: define PE_DIVIDER_SIGNED_EN for two's complement operands
// (truncating division, remainder takes the sign of the dividend).
module pe_divider #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;

`ifdef PE_DIVIDER_SIGNED_EN
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
`endif

    logic             accept;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // A new operation is taken when idle or in the completion cycle (no bubble).
    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    // One restoring step. The partial remainder is always below the divisor, so
    // the WIDTH+1-bit difference lies within (-divisor, divisor) and its top bit
    // is exactly the borrow of the trial subtraction.
    always_comb begin
        partial  = {rem_q, dvd_q[WIDTH-1]};
        trial    = partial - {1'b0, dvs_q};
        borrow   = trial[WIDTH];
        rem_step = borrow ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_step = {dvd_q[WIDTH-2:0], ~borrow};
    end

    // Next-state, operand latching, iteration and result registration.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
`ifdef PE_DIVIDER_SIGNED_EN
        a_raw_d = a_raw_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dvs_q == '0) begin
                    q_d     = '1;
`ifdef PE_DIVIDER_SIGNED_EN
                    r_d     = a_raw_q;
`else
                    r_d     = dvd_q;
`endif
                    dbz_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    rem_d = rem_step;
                    dvd_d = quo_step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
`ifdef PE_DIVIDER_SIGNED_EN
                        q_d = q_neg_q ? -quo_step : quo_step;
                        r_d = r_neg_q ? -rem_step : rem_step;
`else
                        q_d = quo_step;
                        r_d = rem_step;
`endif
                        dbz_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = start ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            rem_d = '0;
            cnt_d = CNT_W'(WIDTH);
`ifdef PE_DIVIDER_SIGNED_EN
            dvd_d   = a[WIDTH-1] ? -a : a;
            dvs_d   = b[WIDTH-1] ? -b : b;
            a_raw_d = a;
            q_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
            r_neg_d = a[WIDTH-1];
`else
            dvd_d = a;
            dvs_d = b;
`endif
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
`ifdef PE_DIVIDER_SIGNED_EN
            a_raw_q <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
`ifdef PE_DIVIDER_SIGNED_EN
            a_raw_q <= a_raw_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
`endif
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dbz_q;

endmodule
